shift_writeback_regfile: RTL and testbench

- Register file and writeback stage of the 16-bit datapath.
- Accepts results from the shift unit and the ALU, holds them for one cycle in a writeback pipeline register, then commits them to the register array.
- Drives the two source operands, RS and RT, back into the shift and ALU stages.
- Forwards pending writeback data to the read ports so back-to-back dependent shifts see fresh values.

---
 rtl/shift_writeback_regfile.sv | 110 +++++++++++
 tb/tb_shift_writeback_regfile.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shift_writeback_regfile.sv
// Writeback pipeline register plus register array for the 16-bit datapath, with pending-result forwarding.
// Optional build macro REGFILE_ZERO_R0_EN makes register 0 a hard-wired zero.
module shift_writeback_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WbValid,
  input  logic [ADDR_W-1:0] WbAddr,
  input  logic [DATA_W-1:0] WbData,
  input  logic [ADDR_W-1:0] RsAddr,
  input  logic [ADDR_W-1:0] RtAddr,
  output logic [DATA_W-1:0] RS,
  output logic [DATA_W-1:0] RT,
  output logic              PendValid,
  output logic [ADDR_W-1:0] PendAddr,
  output logic [15:0]       CommitCount
);

  localparam int NREG = 1 << ADDR_W;

`ifdef REGFILE_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [15:0]       commit_count_q, commit_count_d;
  logic              commit_en;

  // A pending write to a hard-wired zero register is dropped at commit time.
  assign commit_en = pend_valid_q && !(ZERO_R0 && (pend_addr_q == '0));

  always_comb begin
    pend_valid_d   = WbValid;
    pend_addr_d    = WbAddr;
    pend_data_d    = WbData;
    commit_count_d = commit_count_q;
    if (commit_en) begin
      commit_count_d = commit_count_q + 16'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      always_comb begin
        regs_d[gi] = regs_q[gi];
        if (commit_en && (pend_addr_q == ADDR_W'(gi))) begin
          regs_d[gi] = pend_data_q;
        end
      end

      always_ff @(posedge Clock) begin
        if (Reset) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pend_valid_q   <= 1'b0;
      pend_addr_q    <= '0;
      pend_data_q    <= '0;
      commit_count_q <= '0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_addr_q    <= pend_addr_d;
      pend_data_q    <= pend_data_d;
      commit_count_q <= commit_count_d;
    end
  end

  // Both read ports share one priority mux: zero register, then pending data, then array.
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = RsAddr;
  assign rd_addr[1] = RtAddr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = regs_q[rd_addr[gi]];
        if (ZERO_R0 && (rd_addr[gi] == '0)) begin
          rd_data[gi] = '0;
        end else if (pend_valid_q && (pend_addr_q == rd_addr[gi])) begin
          rd_data[gi] = pend_data_q;
        end
      end
    end
  endgenerate

  assign RS          = rd_data[0];
  assign RT          = rd_data[1];
  assign PendValid   = pend_valid_q;
  assign PendAddr    = pend_addr_q;
  assign CommitCount = commit_count_q;

endmodule

// File: tb/tb_shift_writeback_regfile.sv
// Directed self-checking bench for shift_writeback_regfile; expected values are hand-computed constants.
module tb_shift_writeback_regfile;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        WbValid = 1'b0;
  logic [1:0]  WbAddr = 2'd0;
  logic [15:0] WbData = 16'h0000;
  logic [1:0]  RsAddr = 2'd0;
  logic [1:0]  RtAddr = 2'd0;
  logic [15:0] RS, RT, CommitCount;
  logic        PendValid;
  logic [1:0]  PendAddr;

  int checks = 0;
  int errors = 0;

  shift_writeback_regfile #(.DATA_W(16), .ADDR_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RS(RS), .RT(RT),
    .PendValid(PendValid), .PendAddr(PendAddr), .CommitCount(CommitCount)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic write(input logic [1:0] a, input logic [15:0] d);
    WbValid = 1'b1;
    WbAddr  = a;
    WbData  = d;
  endtask

  task automatic idle();
    WbValid = 1'b0;
    WbAddr  = 2'd2;
    WbData  = 16'hBEEF;
  endtask

  initial begin
    // Reset state on all addresses and both ports
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      RsAddr = 2'(a);
      RtAddr = 2'(3 - a);
      #1;
      check("rst_rs", RS, 16'h0000);
      check("rst_rt", RT, 16'h0000);
    end
    check("rst_pend", {15'd0, PendValid}, 16'h0000);
    check("rst_cnt", CommitCount, 16'h0000);

    // Single write to r2 with forwarding, not forwarded in the capture cycle
    RsAddr = 2'd2;
    write(2'd2, 16'h0004);
    #1;
    check("no_same_fwd", RS, 16'h0000);
    tick();
    idle();
    #1;
    check("fwd_rs", RS, 16'h0004);
    check("fwd_pend", {15'd0, PendValid}, 16'h0001);
    check("fwd_paddr", {14'd0, PendAddr}, 16'h0002);
    check("fwd_cnt", CommitCount, 16'h0000);
    tick();
    check("arr_rs", RS, 16'h0004);
    check("arr_pend", {15'd0, PendValid}, 16'h0000);
    check("arr_cnt", CommitCount, 16'h0001);
    tick();
    check("idle_keep", RS, 16'h0004);
    check("idle_cnt", CommitCount, 16'h0001);

    // Back-to-back writes to r1
    RsAddr = 2'd1;
    RtAddr = 2'd1;
    write(2'd1, 16'h0400);
    tick();
    write(2'd1, 16'h0010);
    #1;
    check("b2b1_rs", RS, 16'h0400);
    check("b2b1_rt", RT, 16'h0400);
    tick();
    idle();
    #1;
    check("b2b2_rs", RS, 16'h0010);
    check("b2b2_rt", RT, 16'h0010);
    check("b2b2_cnt", CommitCount, 16'h0002);
    tick();
    check("b2b_arr", RS, 16'h0010);
    check("b2b_cnt", CommitCount, 16'h0003);
    RsAddr = 2'd2;
    #1;
    check("port_a_r2", RS, 16'h0004);
    check("port_b_r1", RT, 16'h0010);

    // Pending result discarded by reset
    RsAddr = 2'd3;
    write(2'd3, 16'hFFFF);
    tick();
    idle();
    #1;
    check("pend_r3", RS, 16'hFFFF);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("disc_r3", RS, 16'h0000);
    check("disc_pend", {15'd0, PendValid}, 16'h0000);
    check("disc_cnt", CommitCount, 16'h0000);
    tick();
    check("disc_r3_late", RS, 16'h0000);
    RtAddr = 2'd2;
    #1;
    check("rst_r2", RT, 16'h0000);

    // Register 0 behaviour
    RsAddr = 2'd0;
    write(2'd0, 16'h1234);
    tick();
    idle();
    #1;
    check("r0_pend", {15'd0, PendValid}, 16'h0001);
`ifdef REGFILE_ZERO_R0_EN
    check("r0_fwd", RS, 16'h0000);
    tick();
    check("r0_arr", RS, 16'h0000);
    check("r0_cnt", CommitCount, 16'h0000);
`else
    check("r0_fwd", RS, 16'h1234);
    tick();
    check("r0_arr", RS, 16'h1234);
    check("r0_cnt", CommitCount, 16'h0001);
`endif

    // Counter wrap: 65535 commits, then one more
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    RsAddr = 2'd1;
    for (int i = 0; i < 65535; i++) begin
      write(2'd1, 16'(i));
      tick();
    end
    idle();
    tick();
    check("cnt_max", CommitCount, 16'hFFFF);
    check("cnt_max_r1", RS, 16'hFFFE);
    write(2'd1, 16'hABCD);
    tick();
    idle();
    tick();
    check("cnt_wrap", CommitCount, 16'h0000);
    check("wrap_r1", RS, 16'hABCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
